bm_dut: RTL and testbench
=========================

BM_DUT -- requirements
Module: bm_dut

Interface
REQ-001 Port clk, input, 1 bit; the block's single clock; the datapath holds no state, so clk is carried for integration only.
REQ-002 Port reset, input, 1 bit; asynchronous, active-low; low forces both outputs to zero immediately.
REQ-003 Port u0, input, 48 bits; uniform sample, unsigned UQ0.48, value u0/2^48.
REQ-004 Port u1, input, 16 bits; uniform sample, unsigned UQ0.16, value u1/2^16.
REQ-005 Port x0, output, 16 bits; Gaussian sample, two's-complement Q5.11 (1 sign, 4 integer, 11 fraction bits).
REQ-006 Port x1, output, 16 bits; second Gaussian sample, Q5.11, paired with x0.

Function
REQ-007 The block SHALL implement the Box-Muller transform: e = -2*ln(u0), f = sqrt(e), x0 = f*sin(2*pi*u1), x1 = f*cos(2*pi*u1).
REQ-008 The outputs SHALL be purely combinational from u0, u1 and reset, with zero clock latency; they SHALL settle within 1 ns of an input change.
REQ-009 Internal e SHALL be unsigned UQ7.24 (31 bits), f unsigned UQ4.13 (17 bits), and the sin/cos terms signed Q1.15 (16 bits).
REQ-010 ln SHALL use range reduction: find the leading one of u0 to get exponent k; normalise the mantissa to [1,2); compute ln(mantissa) by table plus linear interpolation, with at least 64 segments; form ln(u0) = ln(mantissa) - k*ln2.
REQ-011 sqrt SHALL use range reduction to an even exponent, a table plus linear interpolation on the mantissa, then an exponent shift by half.
REQ-012 sin/cos SHALL use the top 2 bits of u1 for quadrant folding and the next bits for a quarter-wave table plus interpolation (at least 128 segments); cos(2*pi*u1) is derived as sin(2*pi*(u1 + 0x4000)).
REQ-013 Quadrant mapping SHALL be as follows: q0 gives (+s, +c); q1 gives (+c, -s) for (sin, cos); q2 gives (-s, -c); q3 gives (-c, +s), where s and c are the first-quadrant values.
REQ-014 The final products f*g SHALL be computed at full precision, then rounded to nearest into Q5.11.
REQ-015 Every output SHALL be within +/-2 LSB (Q5.11) of the ideal real-valued result rounded to nearest.
REQ-016 u0 = 0 SHALL be treated as u0 = 1 (2^-48), giving e = 66.542 and f = 8.1573; this is never an error.
REQ-017 u0 at or near 2^48-1 gives e near 0; f SHALL then be 0 or 1 LSB and never negative.
REQ-018 Outputs SHALL never wrap; the maximum magnitude is 8.16, and saturation at +/-15.999 is still required as a safeguard.
REQ-019 At the exact quadrant boundaries (u1 = 0x0000, 0x4000, 0x8000, 0xC000), sin/cos SHALL give exactly 0 and +/-1.0; +1.0 is represented as 0x7FFF in Q1.15.
REQ-020 x0 and x1 SHALL always be computed from the same (u0, u1) pair; there is no skew between them.

Reset
REQ-021 While reset = 0, x0 = 0x0000 and x1 = 0x0000, regardless of u0 and u1, asynchronously and independent of clk.
REQ-022 On reset release, the outputs SHALL reflect the current inputs within 1 ns; there is no warm-up.
REQ-023 Reset asserted mid-stream SHALL zero the outputs immediately; no clock edge is required.

Verification
REQ-024 reset=1, u0=0x800000000000, u1=0x0000 -> x0=0x0000, x1=0x096B (+/-2 LSB).
REQ-025 reset=1, u0=0x800000000000, u1=0x4000 -> x0=0x096B, x1=0x0000; and with u1=0x8000 -> x0=0x0000, x1=0xF695 (+/-2 LSB).
REQ-026 reset=1, u0=0x000000000000, u1=0x2000 -> x0=x1=0x2E25 (+/-2 LSB), with no saturation.
REQ-027 reset=1, u0=0xFFFFFFFFFFFF with any u1 -> x0 and x1 each within +/-1 LSB of 0x0000.
REQ-028 reset=0 with any inputs -> x0=x1=0x0000.
REQ-029 Then raise reset with u0=0x800000000000, u1=0x0000 -> x1=0x096B within 1 ns.
REQ-030 Apply 10000 random (u0, u1) pairs, one every 3 ns, and sample 1 ns after each change.
- Every sample SHALL match the golden model within +/-2 LSB.
- The sample mean of x0 and x1 SHALL be within 0.03 of 0, and the variance within 0.05 of 1.0.

Source files
------------

// File: rtl/bm_dut.sv
// Box-Muller Gaussian pair generator: two uniform samples in, two Q5.11 normal samples out.
// Purely combinational; the only state is the constant ln/sqrt/sin tables built at elaboration.
`timescale 1ns/1ps

module bm_dut_sin (
  input  logic        [15:0] phase_i,
  output logic signed [15:0] val_o
);

  localparam longint PI_Q30 = 64'sd3373259426;

  // round(sin(i*pi/256) * 2^15) with +1.0 clipped to 0x7FFF; entry 129 duplicates 128.
  function automatic logic [15:0] sin_entry(input int i);
    longint x, x2, term, acc;
    int     j;
    j    = (i > 128) ? 128 : i;
    x    = (longint'(j) * PI_Q30) / longint'(256);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = '0;
    for (int n = 1; n <= 12; n++) begin
      acc  = acc + term;
      term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
    end
    acc = (acc + longint'(16384)) >>> 15;
    if (acc > longint'(32767)) acc = longint'(32767);
    return 16'(acc);
  endfunction

  logic [15:0] sin_tab [130];

  for (genvar g = 0; g < 130; g++) begin : g_sin_tab
    localparam logic [15:0] SinV = sin_entry(g);
    assign sin_tab[g] = SinV;
  end

  logic [1:0]  quad;
  logic [14:0] pos;
  logic [7:0]  idx;
  logic [6:0]  frac;
  logic [15:0] lo;
  logic [15:0] hi;
  logic [22:0] prod;
  logic [15:0] mag;

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    quad  = phase_i[15:14];
    // Odd quadrants walk the quarter-wave backwards, so phase 0 of q1/q3 lands on +1.0.
    pos   = quad[0] ? (15'd16384 - {1'b0, phase_i[13:0]}) : {1'b0, phase_i[13:0]};
    idx   = pos[14:7];
    frac  = pos[6:0];
    lo    = sin_tab[idx];
    hi    = sin_tab[idx + 8'd1];
    prod  = 23'(hi - lo) * 23'(frac);
    mag   = lo + 16'((prod + 23'd64) >> 7);
    val_o = quad[1] ? -$signed(mag) : $signed(mag);
  end

endmodule

module bm_dut (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] u0,
  input  logic [15:0] u1,
  output logic [15:0] x0,
  output logic [15:0] x1
);

  // round(ln(1 + i/256) * 2^28) via 2*atanh((y-1)/(y+1)).
  function automatic logic [31:0] ln_entry(input int i);
    longint z, z2, term, acc;
    z    = (longint'(i) <<< 30) / longint'(512 + i);
    z2   = (z * z) >>> 30;
    term = z;
    acc  = '0;
    for (int n = 0; n < 16; n++) begin
      acc  = acc + term / longint'(2 * n + 1);
      term = (term * z2) >>> 30;
    end
    return 32'((acc + longint'(1)) >>> 1);
  endfunction

  function automatic logic [63:0] isqrt(input logic [63:0] v);
    logic [63:0] rem, res, bit_v;
    rem   = v;
    res   = '0;
    bit_v = 64'h4000_0000_0000_0000;
    for (int n = 0; n < 32; n++) begin
      if (rem >= res + bit_v) begin
        rem = rem - (res + bit_v);
        res = (res >> 1) + bit_v;
      end else begin
        res = res >> 1;
      end
      bit_v = bit_v >> 2;
    end
    return res;
  endfunction

  // round(sqrt(i/128) * 2^24); only entries 64..256 are reached.
  function automatic logic [31:0] sqrt_entry(input int i);
    return 32'((isqrt(64'(i) << 43) + 64'd1) >> 1);
  endfunction

  function automatic logic [15:0] round_sat(input logic signed [33:0] p);
    logic signed [33:0] r;
    r = (p + 34'sd65536) >>> 17;
    if (r > 34'sd32767)       return 16'h7FFF;
    else if (r < -34'sd32767) return 16'h8001;
    else                      return r[15:0];
  endfunction

  localparam logic [31:0] LN2 = ln_entry(256);

  logic [31:0] ln_tab [257];
  logic [31:0] sq_tab [257];

  for (genvar g = 0; g < 257; g++) begin : g_tabs
    localparam logic [31:0] LnV = ln_entry(g);
    localparam logic [31:0] SqV = sqrt_entry(g);
    assign ln_tab[g] = LnV;
    assign sq_tab[g] = SqV;
  end

  // ln stage: u0 = m * 2^-k with m in [1,2); e = 2*(k*ln2 - ln m) in UQ7.24.
  logic [47:0] u0_eff;
  logic [5:0]  msb;
  logic [5:0]  k;
  logic [47:0] norm;
  logic [7:0]  ln_idx;
  logic [19:0] ln_frac;
  logic [31:0] ln_lo;
  logic [31:0] ln_hi;
  logic [31:0] ln_m;
  logic [39:0] kl;
  logic [39:0] e_raw;
  logic [30:0] e_q;

  always_comb begin
    u0_eff = (u0 == '0) ? 48'd1 : u0;
    msb    = '0;
    for (int i = 0; i < 48; i++) begin
      if (u0_eff[i]) msb = 6'(i);
    end
    k       = 6'd48 - msb;
    norm    = u0_eff << (6'd47 - msb);
    ln_idx  = norm[46:39];
    ln_frac = norm[38:19];
    ln_lo   = ln_tab[ln_idx];
    ln_hi   = ln_tab[9'(ln_idx) + 9'd1];
    ln_m    = ln_lo + 32'((64'(ln_hi - ln_lo) * 64'(ln_frac)) >> 20);
    kl      = 40'(k) * 40'(LN2);
    // Clamp keeps e (and therefore f) non-negative when u0 is within an ulp of 1.
    e_raw   = (kl > 40'(ln_m)) ? ((kl - 40'(ln_m)) << 1) : '0;
    e_q     = 31'((e_raw + 40'd8) >> 4);
  end

  // sqrt stage: e = M * 2^(6-sh) with sh even and M in [0.5,2); f in UQ4.13.
  logic [4:0]  e_msb;
  logic [4:0]  sh;
  logic [4:0]  fs;
  logic [30:0] n;
  logic [7:0]  sq_idx;
  logic [15:0] sq_frac;
  logic [31:0] sq_lo;
  logic [31:0] sq_hi;
  logic [31:0] sm;
  logic [31:0] f_full;
  logic [16:0] f_q;

  always_comb begin
    e_msb = '0;
    for (int i = 0; i < 31; i++) begin
      if (e_q[i]) e_msb = 5'(i);
    end
    sh      = 5'd30 - e_msb;
    sh[0]   = 1'b0;
    n       = e_q << sh;
    sq_idx  = n[30:23];
    sq_frac = n[22:7];
    sq_lo   = sq_tab[sq_idx];
    sq_hi   = sq_tab[9'(sq_idx) + 9'd1];
    sm      = sq_lo + 32'((64'(sq_hi - sq_lo) * 64'(sq_frac)) >> 16);
    fs      = 5'd8 + {1'b0, sh[4:1]};
    f_full  = (sm + (32'd1 << (fs - 5'd1))) >> fs;
    f_q     = (e_q == '0) ? '0 : 17'(f_full);
  end

  logic signed [15:0] g_sin;
  logic signed [15:0] g_cos;
  logic signed [33:0] p0;
  logic signed [33:0] p1;

  bm_dut_sin u_sin (
    .phase_i (u1),
    .val_o   (g_sin)
  );

  bm_dut_sin u_cos (
    .phase_i (u1 + 16'h4000),
    .val_o   (g_cos)
  );

  assign p0 = $signed({1'b0, f_q}) * g_sin;
  assign p1 = $signed({1'b0, f_q}) * g_cos;

  assign x0 = reset ? round_sat(p0) : '0;
  assign x1 = reset ? round_sat(p1) : '0;

  logic unused_bits;
  assign unused_bits = ^{clk, norm[47], norm[18:0], n[6:0]};

endmodule

// File: tb/tb_bm_dut.sv
// Scoreboarded bench for bm_dut: directed corner vectors, reset behaviour,
// then 10000 random pairs against a real-valued Box-Muller model plus moment checks.
`timescale 1ns/1ps

module tb_bm_dut;

  logic        clk;
  logic        reset;
  logic [47:0] u0;
  logic [15:0] u1;
  logic [15:0] x0;
  logic [15:0] x1;

  bm_dut dut (
    .clk   (clk),
    .reset (reset),
    .u0    (u0),
    .u1    (u1),
    .x0    (x0),
    .x1    (x1)
  );

  localparam real TWO_PI = 6.283185307179586;
  localparam real TWO_48 = 281474976710656.0;
  localparam int  N_RAND = 10000;

  typedef struct {
    string tag;
    int    x0;
    int    x1;
    int    tol;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  real  sum0 = 0.0, sum1 = 0.0, sq0 = 0.0, sq1 = 0.0;

  initial begin
    clk = 1'b0;
    forever #2.5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_vec++;
    if (got > exp + tol || got < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", tag, got, exp, tol);
    end
  endtask

  function automatic int to_q511(input real v);
    real s;
    s = v * 2048.0;
    if (s > 32767.0)  s = 32767.0;
    if (s < -32767.0) s = -32767.0;
    return $rtoi((s >= 0.0) ? s + 0.5 : s - 0.5);
  endfunction

  function automatic void golden(input logic [47:0] a, input logic [15:0] b,
                                 output int e0, output int e1);
    real uv, f, ph;
    uv = (a == '0) ? 1.0 : real'(a);
    uv = uv / TWO_48;
    f  = $sqrt(-2.0 * $ln(uv));
    ph = TWO_PI * real'(b) / 65536.0;
    e0 = to_q511(f * $sin(ph));
    e1 = to_q511(f * $cos(ph));
  endfunction

  task automatic sample();
    exp_t ex;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 1, 0, 0);
    end else begin
      ex = sb_q.pop_front();
      check({ex.tag, ".x0"}, int'($signed(x0)), ex.x0, ex.tol);
      check({ex.tag, ".x1"}, int'($signed(x1)), ex.x1, ex.tol);
    end
  endtask

  task automatic drive(input logic rst, input logic [47:0] a, input logic [15:0] b,
                       input int e0, input int e1, input int tol, input string tag);
    exp_t ex;
    reset = rst;
    u0    = a;
    u1    = b;
    ex.tag = tag;
    ex.x0  = e0;
    ex.x1  = e1;
    ex.tol = tol;
    sb_q.push_back(ex);
    #1;
    sample();
    #2;
  endtask

  initial begin
    real m0, m1, v0, v1;
    reset = 1'b0;
    u0    = '0;
    u1    = '0;
    #0.5;

    drive(1'b0, 48'h1234_5678_9ABC, 16'h1234, 0, 0, 0, "rst_any");
    drive(1'b0, 48'h0000_0000_0000, 16'h2000, 0, 0, 0, "rst_max");
    drive(1'b1, 48'h8000_0000_0000, 16'h0000, 0, 16'h096B, 2, "release");
    drive(1'b1, 48'h8000_0000_0000, 16'h4000, 16'h096B, 0, 2, "half_q1");
    drive(1'b1, 48'h8000_0000_0000, 16'h8000, 0, int'($signed(16'hF695)), 2, "half_q2");
    drive(1'b1, 48'h8000_0000_0000, 16'hC000, int'($signed(16'hF695)), 0, 2, "half_q3");
    drive(1'b1, 48'h0000_0000_0000, 16'h2000, 16'h2E25, 16'h2E25, 2, "u0_zero");
    drive(1'b1, 48'h0000_0000_0001, 16'h2000, 16'h2E25, 16'h2E25, 2, "u0_one");
    drive(1'b1, 48'hFFFF_FFFF_FFFF, 16'h1357, 0, 0, 1, "u0_max_a");
    drive(1'b1, 48'hFFFF_FFFF_FFFF, 16'hA5A5, 0, 0, 1, "u0_max_b");
    drive(1'b0, 48'h0000_0000_0000, 16'h2000, 0, 0, 0, "rst_mid");

    for (int i = 0; i < N_RAND; i++) begin
      logic [47:0] a;
      logic [15:0] b;
      int          e0, e1;
      a = {16'($urandom()), $urandom()};
      b = 16'($urandom());
      golden(a, b, e0, e1);
      drive(1'b1, a, b, e0, e1, 2, "rand");
      sum0 += real'($signed(x0)) / 2048.0;
      sum1 += real'($signed(x1)) / 2048.0;
      sq0  += (real'($signed(x0)) / 2048.0) ** 2;
      sq1  += (real'($signed(x1)) / 2048.0) ** 2;
    end

    m0 = sum0 / real'(N_RAND);
    m1 = sum1 / real'(N_RAND);
    v0 = sq0 / real'(N_RAND) - m0 * m0;
    v1 = sq1 / real'(N_RAND) - m1 * m1;
    check("mean_x0_milli", $rtoi(m0 * 1000.0), 0, 30);
    check("mean_x1_milli", $rtoi(m1 * 1000.0), 0, 30);
    check("var_x0_milli",  $rtoi(v0 * 1000.0), 1000, 50);
    check("var_x1_milli",  $rtoi(v1 * 1000.0), 1000, 50);
    check("sb_leftover", sb_q.size(), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
